// File: rtl/exec_delay_seq.sv
// Purpose: execute-stage delay sequencer; paces one decoded instruction through a fixed or ALU-terminated delay. Optional watchdog via DLY_TIMEOUT_EN.
// Latency: done_o rises max(dly_i,1) cycles after acceptance (1 if dly_sel_i=0 or dly_i=0), or 1 cycle after alu_done_i for dly_i=255.
// Backpressure: issue_ready_o low in COUNT/WAIT_EXT; a completing instruction (DONE) can hand off to the next one with no bubble.

// Shared operand/delay widths; the fallbacks apply when the shared define file is not in the compile.
`ifndef OPR_W
`define OPR_W 5
`endif
`ifndef DLY_W
`define DLY_W 8
`endif

module exec_delay_seq (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid_i,
    output logic              issue_ready_o,
    input  logic [`OPR_W-1:0] opr_typ_i,
    input  logic              dly_sel_i,
    input  logic [`DLY_W-1:0] dly_i,
    input  logic              alu_done_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              stall_o,
    output logic              done_o,
    output logic [`OPR_W-1:0] done_opr_o
`ifdef DLY_TIMEOUT_EN
    ,
    output logic              err_o
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNT    = 2'd1,
        WAIT_EXT = 2'd2,
        DONE     = 2'd3
    } state_t;

    // All-ones delay marks an open-ended operation finished by alu_done_i.
    localparam logic [`DLY_W-1:0] DLY_EXT = '1;

    state_t            state_q;
    state_t            state_d;
    state_t            acc_tgt;
    logic [`DLY_W-1:0] cnt_q;
    logic [`OPR_W-1:0] opr_q;
    logic              accept;
    logic              timeout;

    // A flush arriving while the current instruction completes blocks the hand-off,
    // even though the ready flag itself stays high in DONE.
    assign accept = issue_valid_i && issue_ready_o && !((state_q == DONE) && flush_i);

    // Destination state for a freshly accepted instruction. A delay of 1 is already
    // at the counter's terminal value, so it goes straight to DONE to keep the
    // "done exactly dly cycles later" timing; only 2..254 ever enter COUNT.
    always_comb begin
        acc_tgt = COUNT;
        if (!dly_sel_i || (dly_i <= `DLY_W'(1))) begin
            acc_tgt = DONE;
        end else if (dly_i == DLY_EXT) begin
            acc_tgt = WAIT_EXT;
        end
    end

`ifdef DLY_TIMEOUT_EN
    logic [9:0] wdog_q;
    logic       err_q;

    // Give up after the 1023rd WAIT_EXT cycle without an ALU completion.
    assign timeout = (state_q == WAIT_EXT) && !flush_i && !alu_done_i && (wdog_q == 10'd1022);

    // Watchdog counts WAIT_EXT residency; the error flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q <= 10'd0;
            err_q  <= 1'b0;
        end else begin
            if (state_q == WAIT_EXT) begin
                wdog_q <= wdog_q + 10'd1;
            end else begin
                wdog_q <= 10'd0;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;
`else
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush and watchdog abort win over completion conditions.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = acc_tgt;
                end
            end
            COUNT: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (cnt_q <= `DLY_W'(2)) begin
                    state_d = DONE;
                end
            end
            WAIT_EXT: begin
                if (flush_i || timeout) begin
                    state_d = IDLE;
                end else if (alu_done_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = accept ? acc_tgt : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Delay counter and opcode latch; counter is zero whenever not counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            opr_q <= '0;
        end else begin
            if (accept) begin
                opr_q <= opr_typ_i;
            end
            if (accept && (acc_tgt == COUNT)) begin
                cnt_q <= dly_i;
            end else if ((state_q == COUNT) && (state_d == COUNT)) begin
                cnt_q <= cnt_q - `DLY_W'(1);
            end else begin
                cnt_q <= '0;
            end
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        issue_ready_o = 1'b0;
        busy_o        = 1'b0;
        stall_o       = 1'b0;
        done_o        = 1'b0;
        done_opr_o    = '0;
        case (state_q)
            IDLE: begin
                issue_ready_o = 1'b1;
            end
            COUNT, WAIT_EXT: begin
                busy_o  = 1'b1;
                stall_o = 1'b1;
            end
            DONE: begin
                issue_ready_o = 1'b1;
                busy_o        = 1'b1;
                done_o        = 1'b1;
                done_opr_o    = opr_q;
            end
            default: begin
                issue_ready_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_exec_delay_seq.sv
// Purpose: self-checking bench for exec_delay_seq (table vectors, directed corner sequences, randomized traffic vs. reference model).
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled in the same window before the next edge.
// Backpressure: model tracks the in-flight instruction and its completion cycle; flush/reset/watchdog abort it.

`ifndef OPR_W
`define OPR_W 5
`endif
`ifndef DLY_W
`define DLY_W 8
`endif

module tb_exec_delay_seq;

    logic              clk = 1'b0;
    logic              rst;
    logic              issue_valid_i;
    logic              issue_ready_o;
    logic [`OPR_W-1:0] opr_typ_i;
    logic              dly_sel_i;
    logic [`DLY_W-1:0] dly_i;
    logic              alu_done_i;
    logic              flush_i;
    logic              busy_o;
    logic              stall_o;
    logic              done_o;
    logic [`OPR_W-1:0] done_opr_o;
`ifdef DLY_TIMEOUT_EN
    logic              err_o;
`endif

    exec_delay_seq dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid_i (issue_valid_i),
        .issue_ready_o (issue_ready_o),
        .opr_typ_i     (opr_typ_i),
        .dly_sel_i     (dly_sel_i),
        .dly_i         (dly_i),
        .alu_done_i    (alu_done_i),
        .flush_i       (flush_i),
        .busy_o        (busy_o),
        .stall_o       (stall_o),
        .done_o        (done_o),
        .done_opr_o    (done_opr_o)
`ifdef DLY_TIMEOUT_EN
        ,
        .err_o         (err_o)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit chk_en = 0;

    // Reference model: one in-flight slot with an absolute completion cycle.
    bit                m_fl   = 0;
    bit                m_ext  = 0;
    int                m_due  = -1;
    int                m_wait = 0;
    bit                m_err  = 0;
    logic [`OPR_W-1:0] m_opr  = '0;

    typedef struct {
        bit v;  int opr; bit sel; int dly; bit alu; bit fl;
        bit e_rdy; bit e_busy; bit e_stall; bit e_done; int e_opr;
    } vec_t;
    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input bit v, input int opr, input bit sel, input int dly,
                         input bit alu, input bit fl);
        rst           = 1'b0;
        issue_valid_i = v;
        opr_typ_i     = opr[`OPR_W-1:0];
        dly_sel_i     = sel;
        dly_i         = dly[`DLY_W-1:0];
        alu_done_i    = alu;
        flush_i       = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic model_accept();
        m_fl  = 1;
        m_ext = 0;
        m_opr = opr_typ_i;
        if (!dly_sel_i || dly_i == 0) begin
            m_due = cyc + 1;
        end else if (dly_i == 8'd255) begin
            m_ext  = 1;
            m_wait = 0;
            m_due  = -1;
        end else begin
            m_due = cyc + int'(dly_i);
        end
    endtask

    // Compare this cycle's outputs against the model, advance the model, then clock.
    task automatic tick();
        bit dn;
        dn = m_fl && !m_ext && (cyc == m_due);
        if (chk_en) begin
            chk("ready", issue_ready_o, !m_fl || dn);
            chk("busy", busy_o, m_fl);
            chk("stall", stall_o, m_fl && !dn);
            chk("done", done_o, dn);
            chk("done_opr", done_opr_o, dn ? m_opr : '0);
`ifdef DLY_TIMEOUT_EN
            chk("err", err_o, m_err);
`endif
        end
        if (rst) begin
            m_fl  = 0;
            m_ext = 0;
            m_err = 0;
        end else if (m_fl && !dn) begin
            if (flush_i) begin
                m_fl  = 0;
                m_ext = 0;
            end else if (m_ext) begin
                if (alu_done_i) begin
                    m_ext = 0;
                    m_due = cyc + 1;
                end else begin
                    m_wait++;
`ifdef DLY_TIMEOUT_EN
                    if (m_wait == 1023) begin
                        m_fl  = 0;
                        m_ext = 0;
                        m_err = 1;
                    end
`endif
                end
            end
        end else begin
            m_fl = 0;
            if (issue_valid_i && !(dn && flush_i)) begin
                model_accept();
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        int a;
        int r;
        int d;

        // Reset: two edges with garbage inputs must be overridden.
        drive(1, 3, 1, 5, 1, 0);
        rst = 1'b1;
        tick();
        tick();
        chk_en = 1;
        idle();
        chk("rst_ready", issue_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_opr", done_opr_o, 0);
`ifdef DLY_TIMEOUT_EN
        chk("rst_err", err_o, 0);
`endif
        while (cyc < 10) tick();

        // ADD accepted at cycle 10, done at 14, stall over 11..13.
        drive(1, 2, 1, 4, 0, 0);
        tick();
        for (int c = 11; c <= 15; c++) begin
            idle();
            chk("add_done", done_o, c == 14);
            chk("add_opr", done_opr_o, (c == 14) ? 2 : 0);
            chk("add_stall", stall_o, (c >= 11 && c <= 13));
            tick();
        end

        // Table vectors starting from IDLE.
        tbl[0]  = '{1, 3, 0, 9, 0, 0,  1, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 0,  1, 1, 0, 1, 3};
        tbl[2]  = '{1, 5, 1, 2, 0, 0,  1, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 0, 0,  1, 1, 0, 1, 5};
        tbl[5]  = '{1, 6, 1, 0, 0, 0,  1, 0, 0, 0, 0};
        tbl[6]  = '{1, 7, 1, 1, 0, 0,  1, 1, 0, 1, 6};
        tbl[7]  = '{0, 0, 0, 0, 0, 0,  1, 1, 0, 1, 7};
        tbl[8]  = '{1, 8, 1, 3, 0, 1,  1, 0, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 0, 1, 0,  0, 1, 1, 0, 0};
        tbl[10] = '{0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0};
        tbl[11] = '{1, 9, 1, 0, 0, 1,  1, 1, 0, 1, 8};
        tbl[12] = '{0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0};
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v, tbl[i].opr, tbl[i].sel, tbl[i].dly, tbl[i].alu, tbl[i].fl);
            chk($sformatf("tbl%0d_ready", i), issue_ready_o, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_busy", i), busy_o, tbl[i].e_busy);
            chk($sformatf("tbl%0d_stall", i), stall_o, tbl[i].e_stall);
            chk($sformatf("tbl%0d_done", i), done_o, tbl[i].e_done);
            chk($sformatf("tbl%0d_opr", i), done_opr_o, tbl[i].e_opr);
            tick();
        end

        // Fixed delay with alu_done_i pulses during COUNT: timing must not move.
        drive(1, 1, 1, 6, 0, 0);
        tick();
        for (int k = 1; k <= 7; k++) begin
            drive(0, 0, 0, 0, (k == 2 || k == 4), 0);
            chk("cnt_alu_done", done_o, k == 6);
            tick();
        end

        // MUL open-ended: alu_done_i 10 cycles in, done on the following cycle only.
        drive(1, 4, 1, 255, 0, 0);
        tick();
        for (int k = 1; k <= 14; k++) begin
            drive(0, 0, 0, 0, (k == 10 || k == 13), 0);
            chk("mul_done", done_o, k == 11);
            chk("mul_opr", done_opr_o, (k == 11) ? 4 : 0);
            chk("mul_stall", stall_o, (k >= 1 && k <= 10));
            tick();
        end

        // Open-ended with alu_done_i in the very first WAIT_EXT cycle.
        drive(1, 11, 1, 255, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 0);
        tick();
        idle();
        chk("ext_first_done", done_o, 1);
        chk("ext_first_opr", done_opr_o, 11);
        tick();

        // Back-to-back: X done -> MOV (dly=1) -> INV (dly=21), no idle gap.
        drive(1, 3, 1, 3, 0, 0);
        tick();
        idle(); tick();
        idle(); tick();
        drive(1, 6, 1, 1, 0, 0);
        chk("b2b_x_done", done_opr_o, 3);
        tick();
        drive(1, 9, 1, 21, 0, 0);
        chk("b2b_mov_done", done_opr_o, 6);
        chk("b2b_mov_ready", issue_ready_o, 1);
        tick();
        for (int k = 5; k <= 26; k++) begin
            idle();
            chk("b2b_inv_done", done_o, k == 25);
            chk("b2b_busy", busy_o, k <= 25);
            tick();
        end

        // JRE flushed in its third COUNT cycle.
        drive(1, 17, 1, 7, 0, 0);
        tick();
        for (int k = 1; k <= 9; k++) begin
            drive(0, 0, 0, 0, 0, (k == 3));
            if (k >= 4) begin
                chk("jre_no_done", done_o, 0);
                chk("jre_ready", issue_ready_o, 1);
                chk("jre_busy", busy_o, 0);
            end
            tick();
        end

        // Reset while in WAIT_EXT discards the instruction.
        drive(1, 12, 1, 255, 0, 0);
        tick();
        for (int k = 1; k <= 8; k++) begin
            drive(0, 0, 0, 0, (k == 6), 0);
            rst = (k == 5);
            if (k >= 6) begin
                chk("wrst_ready", issue_ready_o, 1);
                chk("wrst_busy", busy_o, 0);
                chk("wrst_stall", stall_o, 0);
                chk("wrst_done", done_o, 0);
                chk("wrst_opr", done_opr_o, 0);
            end
            tick();
        end

`ifdef DLY_TIMEOUT_EN
        // DIV never completes: watchdog fires after 1023 WAIT_EXT cycles.
        drive(1, 13, 1, 255, 0, 0);
        tick();
        for (int k = 1; k <= 1030; k++) begin
            idle();
            chk("wd_err", err_o, k >= 1024);
            chk("wd_done", done_o, 0);
            chk("wd_busy", busy_o, k <= 1023);
            tick();
        end
        drive(1, 2, 1, 2, 0, 0);
        tick();
        idle(); tick();
        chk("wd_err_held", err_o, 1);
        rst = 1'b1;
        tick();
        idle();
        chk("wd_err_clr", err_o, 0);
`endif

        // Randomized traffic checked cycle-by-cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 7);
            case (r)
                0: d = 0;
                1: d = 1;
                2: d = 2;
                3: d = 255;
                default: d = $urandom_range(3, 30);
            endcase
            drive($urandom_range(0, 9) < 6, $urandom_range(0, (1 << `OPR_W) - 1),
                  $urandom_range(0, 19) < 17, d,
                  $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 6);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
